// File: rtl/game_pkg.sv
// Shared game types and datapath widths for the sequencer, bit-mask lookup and renderer.
package game_pkg;

  localparam int STATE_W    = 3;
  localparam int WALL_IDX_W = 4;
  localparam int DEPTH_W    = 8;
  localparam int FPT_W      = 4;
  localparam int ROUND_W    = 8;
  localparam int COUNT_W    = 8;
  localparam int STRIKE_W   = 8;
  localparam int COLL_W     = 21;

  typedef enum logic [STATE_W-1:0] {
    ST_LOSE      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WIN       = 3'd2,
    ST_COUNTDOWN = 3'd3,
    ST_ADVANCE   = 3'd4
  } game_state_t;

  // Frames per depth step for a round: linear speedup clamped at the floor.
  // Signed arithmetic so a large round count cannot wrap below the floor.
  function automatic logic [FPT_W-1:0] speed_for_round(input int rnd, input int max_f,
                                                       input int step, input int min_f);
    int v;
    v = max_f - rnd * step;
    if (v < min_f) v = min_f;
    return FPT_W'(v);
  endfunction

  function automatic logic depth_in_window(input logic [DEPTH_W-1:0] d, input int goal,
                                           input int delta);
    int di;
    di = int'(32'(d));
    return (di >= goal - delta) && (di <= goal + delta);
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Frame-side inputs and wall/game-state outputs of the round sequencer.
interface round_sequencer_if;
  import game_pkg::*;

  logic                  start_game_in;
  logic                  frame_done_in;
  logic [COLL_W-1:0]     frame_collisions_in;
  logic [WALL_IDX_W-1:0] wall_idx_out;
  logic [DEPTH_W-1:0]    wall_depth_out;
  logic                  wall_tick_out;
  logic [FPT_W-1:0]      frames_per_tick_out;
  logic [ROUND_W-1:0]    round_out;
  logic [COUNT_W-1:0]    countdown_out;
  logic                  in_window_out;
  logic [STATE_W-1:0]    game_state_out;

  modport master (
    output start_game_in, frame_done_in, frame_collisions_in,
    input  wall_idx_out, wall_depth_out, wall_tick_out, frames_per_tick_out,
           round_out, countdown_out, in_window_out, game_state_out
  );

  modport slave (
    input  start_game_in, frame_done_in, frame_collisions_in,
    output wall_idx_out, wall_depth_out, wall_tick_out, frames_per_tick_out,
           round_out, countdown_out, in_window_out, game_state_out
  );
endinterface

// File: rtl/round_sequencer_wall_tick_gen.sv
// Frame counter that emits a depth-step strobe every frames_per_tick frames.
module wall_tick_gen
  import game_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             enable,
  input  logic             frame_done,
  input  logic [FPT_W-1:0] frames_per_tick,
  output logic             tick
);

  logic [FPT_W-1:0] frame_cnt;

  // Strobe on the frame that completes the current speed period.
  always_comb
    tick = enable && frame_done && (frame_cnt == frames_per_tick - FPT_W'(1));

  // Count frames within the period; restart on clear or after each strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear)             frame_cnt <= '0;
    else if (enable && frame_done)   frame_cnt <= tick ? '0 : frame_cnt + FPT_W'(1);
  end

endmodule

// File: rtl/round_sequencer.sv
// Game-level sequencer: countdown, wall advance, strike judging and win/lose.
module round_sequencer
  import game_pkg::*;
#(
  parameter int MAX_ROUNDS               = 5,
  parameter int NUM_WALLS                = 10,
  parameter int MAX_FRAMES_PER_WALL_TICK = 15,
  parameter int MIN_FRAMES_PER_WALL_TICK = 3,
  parameter int SPEEDUP_STEP             = 2,
  parameter int GOAL_DEPTH               = 60,
  parameter int GOAL_DEPTH_DELTA         = 10,
  parameter int MAX_WALL_DEPTH           = GOAL_DEPTH + GOAL_DEPTH_DELTA + 5,
  parameter int COUNTDOWN_FRAMES         = 180,
  parameter int COLLISION_THRESHOLD      = 65536,
  parameter int STRIKE_FRAMES            = 3
) (
  input logic              clk_in,
  input logic              rst_in,
  round_sequencer_if.slave bus
);

  game_state_t           state_q, state_d;
  logic [ROUND_W-1:0]    round_q;
  logic [WALL_IDX_W-1:0] wall_q;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [STRIKE_W-1:0]   strikes_q, strikes_inc;
  logic [FPT_W-1:0]      fpt_q;
  logic [COUNT_W-1:0]    countdown_q;
  logic                  tick_q, win_q;

  logic start_evt, fd_cd, cd_done, fd_adv, tick, hit, lose, round_end, last_round;

  wall_tick_gen u_tick (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .clear           (start_evt || cd_done),
    .enable          (state_q == ST_ADVANCE),
    .frame_done      (bus.frame_done_in),
    .frames_per_tick (fpt_q),
    .tick            (tick)
  );

  // Frame-boundary events; judging uses the depth before this frame's update.
  always_comb begin
    start_evt   = bus.start_game_in &&
                  (state_q == ST_IDLE || state_q == ST_WIN || state_q == ST_LOSE);
    fd_cd       = bus.frame_done_in && (state_q == ST_COUNTDOWN);
    cd_done     = fd_cd && (countdown_q == COUNT_W'(1));
    fd_adv      = bus.frame_done_in && (state_q == ST_ADVANCE);
    hit         = depth_in_window(depth_q, GOAL_DEPTH, GOAL_DEPTH_DELTA) &&
                  (int'(32'(bus.frame_collisions_in)) >= COLLISION_THRESHOLD);
    strikes_inc = strikes_q + STRIKE_W'(1);
    lose        = fd_adv && hit && (int'(32'(strikes_inc)) >= STRIKE_FRAMES);
    round_end   = fd_adv && tick && (int'(32'(depth_q)) == MAX_WALL_DEPTH - 1);
    last_round  = (int'(32'(round_q)) + 1 == MAX_ROUNDS);
  end

  // Next state; a losing frame outranks a round-ending tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: if (start_evt) state_d = ST_COUNTDOWN;
      ST_COUNTDOWN:             if (cd_done)   state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        if (lose)           state_d = ST_LOSE;
        else if (round_end) state_d = last_round ? ST_WIN : ST_COUNTDOWN;
      end
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Next depth; frozen on the losing frame and outside ADVANCE.
  always_comb begin
    depth_d = depth_q;
    if (start_evt || cd_done)        depth_d = '0;
    else if (fd_adv && tick && !lose) depth_d = round_end ? '0 : depth_q + DEPTH_W'(1);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Round bookkeeping, strikes, countdown and registered depth/window/tick.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      round_q     <= '0;
      wall_q      <= '0;
      depth_q     <= '0;
      strikes_q   <= '0;
      fpt_q       <= FPT_W'(MAX_FRAMES_PER_WALL_TICK);
      countdown_q <= '0;
      tick_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      depth_q <= depth_d;
      win_q   <= depth_in_window(depth_d, GOAL_DEPTH, GOAL_DEPTH_DELTA);
      tick_q  <= fd_adv && tick && !lose;
      if (start_evt) begin
        round_q     <= '0;
        wall_q      <= '0;
        strikes_q   <= '0;
        fpt_q       <= FPT_W'(MAX_FRAMES_PER_WALL_TICK);
        countdown_q <= COUNT_W'(COUNTDOWN_FRAMES);
      end else if (fd_cd) begin
        countdown_q <= countdown_q - COUNT_W'(1);
      end else if (fd_adv) begin
        strikes_q <= hit ? strikes_inc : '0;
        if (round_end && !lose && !last_round) begin
          round_q     <= round_q + ROUND_W'(1);
          wall_q      <= (int'(32'(wall_q)) == NUM_WALLS - 1) ? '0 : wall_q + WALL_IDX_W'(1);
          fpt_q       <= speed_for_round(int'(32'(round_q)) + 1, MAX_FRAMES_PER_WALL_TICK,
                                         SPEEDUP_STEP, MIN_FRAMES_PER_WALL_TICK);
          strikes_q   <= '0;
          countdown_q <= COUNT_W'(COUNTDOWN_FRAMES);
        end
      end
    end
  end

  // Outputs straight from registers.
  always_comb begin
    bus.wall_idx_out        = wall_q;
    bus.wall_depth_out      = depth_q;
    bus.wall_tick_out       = tick_q;
    bus.frames_per_tick_out = fpt_q;
    bus.round_out           = round_q;
    bus.countdown_out       = countdown_q;
    bus.in_window_out       = win_q;
    bus.game_state_out      = state_q;
  end

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  localparam int S_STATE = 0, S_WALL = 1, S_DEPTH = 2, S_TICK = 3,
                 S_FPT = 4, S_ROUND = 5, S_CD = 6, S_WIN = 7;

  typedef struct {
    string name;
    int    dut;
    int    sel;
    int    exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  round_sequencer_if if0 ();
  round_sequencer_if if1 ();
  round_sequencer_if if2 ();

  round_sequencer u_d0 (.clk_in(clk), .rst_in(rst), .bus(if0));

  round_sequencer #(
    .COUNTDOWN_FRAMES(2), .MAX_WALL_DEPTH(8), .MAX_FRAMES_PER_WALL_TICK(4),
    .MIN_FRAMES_PER_WALL_TICK(1), .NUM_WALLS(3)
  ) u_d1 (.clk_in(clk), .rst_in(rst), .bus(if1));

  round_sequencer #(
    .COUNTDOWN_FRAMES(1), .MAX_WALL_DEPTH(4), .MAX_FRAMES_PER_WALL_TICK(5),
    .MIN_FRAMES_PER_WALL_TICK(3), .SPEEDUP_STEP(2), .GOAL_DEPTH(2), .GOAL_DEPTH_DELTA(2)
  ) u_d2 (.clk_in(clk), .rst_in(rst), .bus(if2));

  function automatic int pick(input int sel, input int st, input int wi, input int dp,
                              input int tk, input int fp, input int rn, input int cd,
                              input int iw);
    case (sel)
      S_STATE: return st;
      S_WALL:  return wi;
      S_DEPTH: return dp;
      S_TICK:  return tk;
      S_FPT:   return fp;
      S_ROUND: return rn;
      S_CD:    return cd;
      default: return iw;
    endcase
  endfunction

  function automatic int rd(input int d, input int sel);
    case (d)
      0: return pick(sel, int'(if0.game_state_out), int'(if0.wall_idx_out),
                     int'(if0.wall_depth_out), int'(if0.wall_tick_out),
                     int'(if0.frames_per_tick_out), int'(if0.round_out),
                     int'(if0.countdown_out), int'(if0.in_window_out));
      1: return pick(sel, int'(if1.game_state_out), int'(if1.wall_idx_out),
                     int'(if1.wall_depth_out), int'(if1.wall_tick_out),
                     int'(if1.frames_per_tick_out), int'(if1.round_out),
                     int'(if1.countdown_out), int'(if1.in_window_out));
      default: return pick(sel, int'(if2.game_state_out), int'(if2.wall_idx_out),
                     int'(if2.wall_depth_out), int'(if2.wall_tick_out),
                     int'(if2.frames_per_tick_out), int'(if2.round_out),
                     int'(if2.countdown_out), int'(if2.in_window_out));
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      int   act;
      e   = sb_q.pop_front();
      act = rd(e.dut, e.sel);
      n_checks++;
      if (act == e.exp) n_pass++;
      else $display("FAIL %s (dut%0d): got %0d expected %0d", e.name, e.dut, act, e.exp);
    end
  end

  task automatic ex(input string name, input int d, input int sel, input int val);
    exp_t e;
    e.name = name; e.dut = d; e.sel = sel; e.exp = val;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int d, input logic st, input logic fd, input int coll);
    case (d)
      0: begin if0.start_game_in = st; if0.frame_done_in = fd; if0.frame_collisions_in = 21'(coll); end
      1: begin if1.start_game_in = st; if1.frame_done_in = fd; if1.frame_collisions_in = 21'(coll); end
      default: begin if2.start_game_in = st; if2.frame_done_in = fd; if2.frame_collisions_in = 21'(coll); end
    endcase
  endtask

  task automatic step(input int d, input logic st, input logic fd, input int coll);
    drive(d, st, fd, coll);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 0);
  endtask

  task automatic frames(input int d, input int n, input int coll);
    repeat (n) step(d, 1'b0, 1'b1, coll);
  endtask

  task automatic start_game(input int d);
    step(d, 1'b1, 1'b0, 0);
  endtask

  task automatic ex_reset(input int d, input int fpt);
    ex("rst_state", d, S_STATE, 1);
    ex("rst_wall",  d, S_WALL,  0);
    ex("rst_depth", d, S_DEPTH, 0);
    ex("rst_tick",  d, S_TICK,  0);
    ex("rst_fpt",   d, S_FPT,   fpt);
    ex("rst_round", d, S_ROUND, 0);
    ex("rst_cd",    d, S_CD,    0);
    ex("rst_win",   d, S_WIN,   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int coll_seq[6];
    int fpt_seq[5];
    coll_seq = '{70000, 70000, 10, 70000, 70000, 70000};
    fpt_seq  = '{5, 3, 3, 3, 3};
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    if (if0.game_state_out !== 3'd1) $display("FAIL direct rst state dut0: %0d", if0.game_state_out);
    if (if0.frames_per_tick_out !== 4'd15) $display("FAIL direct rst fpt dut0: %0d", if0.frames_per_tick_out);
    if (if1.frames_per_tick_out !== 4'd4) $display("FAIL direct rst fpt dut1: %0d", if1.frames_per_tick_out);
    ex_reset(0, 15);
    ex_reset(1, 4);

    start_game(1);
    ex("d1_start_state", 1, S_STATE, 3); ex("d1_start_cd", 1, S_CD, 2);
    frames(1, 1, 0);
    ex("d1_cd1", 1, S_CD, 1); ex("d1_cd1_state", 1, S_STATE, 3);
    frames(1, 1, 0);
    ex("d1_adv_state", 1, S_STATE, 4); ex("d1_adv_depth", 1, S_DEPTH, 0);
    for (int i = 0; i < 8; i++) begin
      frames(1, 1, 0);
      ex("d1_tick", 1, S_TICK, (i % 4 == 3) ? 1 : 0);
      ex("d1_depth", 1, S_DEPTH, (i + 1) / 4);
    end
    frames(1, 24, 0);
    ex("d1_r1_state", 1, S_STATE, 3); ex("d1_r1_round", 1, S_ROUND, 1);
    ex("d1_r1_wall", 1, S_WALL, 1);   ex("d1_r1_fpt", 1, S_FPT, 2);
    ex("d1_r1_depth", 1, S_DEPTH, 0); ex("d1_r1_cd", 1, S_CD, 2);
    frames(1, 2 + 16, 0);
    ex("d1_r2_round", 1, S_ROUND, 2); ex("d1_r2_wall", 1, S_WALL, 2);
    ex("d1_r2_fpt", 1, S_FPT, 1);
    frames(1, 2 + 8, 0);
    ex("d1_r3_round", 1, S_ROUND, 3); ex("d1_r3_wall_wrap", 1, S_WALL, 0);
    frames(1, 2 + 8, 0);
    ex("d1_r4_round", 1, S_ROUND, 4); ex("d1_r4_wall", 1, S_WALL, 1);
    frames(1, 2 + 8, 0);
    ex("d1_win_state", 1, S_STATE, 2); ex("d1_win_round", 1, S_ROUND, 4);
    ex("d1_win_wall", 1, S_WALL, 1);
    frames(1, 1, 0);
    ex("d1_win_hold", 1, S_STATE, 2); ex("d1_win_notick", 1, S_TICK, 0);
    ex("d1_win_depth", 1, S_DEPTH, 0);
    start_game(1);
    ex("d1_restart_state", 1, S_STATE, 3); ex("d1_restart_round", 1, S_ROUND, 0);
    ex("d1_restart_wall", 1, S_WALL, 0);   ex("d1_restart_fpt", 1, S_FPT, 4);

    start_game(2);
    ex("d2_start_cd", 2, S_CD, 1);
    for (int r = 0; r < 5; r++) begin
      frames(2, 1, 0);
      ex("d2_adv_state", 2, S_STATE, 4);
      ex("d2_fpt", 2, S_FPT, fpt_seq[r]);
      ex("d2_round", 2, S_ROUND, r);
      frames(2, 4 * fpt_seq[r], 0);
      ex("d2_round_end_state", 2, S_STATE, (r < 4) ? 3 : 2);
    end
    start_game(2);
    ex("d2_start_from_win", 2, S_STATE, 3);
    frames(2, 1, 0);
    frames(2, 15, 0);
    ex("d2_last_depth", 2, S_DEPTH, 3); ex("d2_last_in_window", 2, S_WIN, 1);
    frames(2, 2, 0);
    frames(2, 1, 65536);
    ex("d2_strike1", 2, S_STATE, 4);
    frames(2, 1, 70000);
    ex("d2_strike2", 2, S_STATE, 4);
    frames(2, 1, 65536);
    ex("d2_lose_over_round_end", 2, S_STATE, 0);
    ex("d2_lose_round", 2, S_ROUND, 0);
    ex("d2_lose_notick", 2, S_TICK, 0);

    start_game(0);
    ex("d0_start_state", 0, S_STATE, 3); ex("d0_start_cd", 0, S_CD, 180);
    ex("d0_start_fpt", 0, S_FPT, 15);
    frames(0, 179, 0);
    ex("d0_cd_last", 0, S_CD, 1); ex("d0_cd_state", 0, S_STATE, 3);
    frames(0, 1, 0);
    ex("d0_adv_state", 0, S_STATE, 4); ex("d0_adv_depth", 0, S_DEPTH, 0);
    ex("d0_adv_cd", 0, S_CD, 0);
    frames(0, 14, 0);
    ex("d0_pre_tick", 0, S_TICK, 0); ex("d0_pre_depth", 0, S_DEPTH, 0);
    frames(0, 1, 0);
    ex("d0_tick", 0, S_TICK, 1); ex("d0_depth1", 0, S_DEPTH, 1);
    frames(0, 48 * 15, 0);
    ex("d0_depth49", 0, S_DEPTH, 49); ex("d0_win49", 0, S_WIN, 0);
    frames(0, 15, 0);
    ex("d0_depth50", 0, S_DEPTH, 50); ex("d0_win50", 0, S_WIN, 1);
    frames(0, 5 * 15, 0);
    ex("d0_depth55", 0, S_DEPTH, 55);
    for (int i = 0; i < 6; i++) begin
      frames(0, 1, coll_seq[i]);
      ex("d0_strike_seq_state", 0, S_STATE, (i == 5) ? 0 : 4);
    end
    ex("d0_lose_depth", 0, S_DEPTH, 55); ex("d0_lose_round", 0, S_ROUND, 0);
    frames(0, 1, 0);
    ex("d0_lose_hold", 0, S_STATE, 0); ex("d0_lose_depth_hold", 0, S_DEPTH, 55);
    start_game(0);
    ex("d0_start_from_lose", 0, S_STATE, 3); ex("d0_restart_depth", 0, S_DEPTH, 0);
    frames(0, 180, 0);
    frames(0, 40 * 15, 0);
    ex("d0_depth40", 0, S_DEPTH, 40); ex("d0_win40", 0, S_WIN, 0);
    for (int i = 0; i < 6; i++) frames(0, 1, coll_seq[i]);
    ex("d0_no_lose_outside", 0, S_STATE, 4); ex("d0_depth40_hold", 0, S_DEPTH, 40);
    frames(0, 519, 0);
    ex("d0_r1_state", 0, S_STATE, 3); ex("d0_r1_round", 0, S_ROUND, 1);
    ex("d0_r1_wall", 0, S_WALL, 1);   ex("d0_r1_fpt", 0, S_FPT, 13);
    ex("d0_r1_cd", 0, S_CD, 180);     ex("d0_r1_depth", 0, S_DEPTH, 0);
    frames(0, 180, 0);
    start_game(0);
    ex("d0_start_ignored", 0, S_STATE, 4); ex("d0_start_ignored_round", 0, S_ROUND, 1);
    frames(0, 75 * 13, 0);
    ex("d0_r2_round", 0, S_ROUND, 2); ex("d0_r2_fpt", 0, S_FPT, 11);
    frames(0, 180 + 30 * 11, 0);
    ex("d0_mid_depth", 0, S_DEPTH, 30); ex("d0_mid_state", 0, S_STATE, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_reset(0, 15);

    @(negedge clk);
    #1;
    if (n_checks == 0) $display("FAIL no scoreboard checks ran");
    if (n_pass != n_checks) $display("FAIL %0d scoreboard mismatches", n_checks - n_pass);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Frame-rate game sequencer that drives the wall datapath through a full game. It steps through countdown, wall advance and collision judging, then declares win or lose. It consumes per-frame collision totals from the pixel pipeline and produces the wall index, wall depth, wall tick and game state used by the bit-mask lookup and the renderer. All decisions happen on frame boundaries, and every output is registered.

## Interface
Parameters:
- MAX_ROUNDS, 5, rounds to clear for a win
- NUM_WALLS, 10, wall bit masks available; index wraps
- MAX_FRAMES_PER_WALL_TICK, 15, frames per depth step in round 0
- MIN_FRAMES_PER_WALL_TICK, 3, speed floor
- SPEEDUP_STEP, 2, frames-per-tick removed per round
- GOAL_DEPTH, 60; GOAL_DEPTH_DELTA, 10, judging window [GOAL-DELTA, GOAL+DELTA]
- MAX_WALL_DEPTH, GOAL_DEPTH+GOAL_DEPTH_DELTA+5, depth count per round (0..MAX-1)
- COUNTDOWN_FRAMES, 180, pre-round frames, must be ≥1
- COLLISION_THRESHOLD, 65536, per-frame collision pixels counted as a strike
- STRIKE_FRAMES, 3, consecutive strike frames that lose the game

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- start_game_in  in  1  level; honoured only in IDLE/WIN/LOSE
- frame_done_in  in  1  one-cycle pulse on last valid pixel of a frame
- frame_collisions_in  in  21  collision pixels of the finished frame, valid with frame_done_in
- wall_idx_out  out  4  current wall bit-mask index
- wall_depth_out  out  8  current wall depth
- wall_tick_out  out  1  one-cycle pulse per depth increment
- frames_per_tick_out  out  4  active speed
- round_out  out  8  current round, 0-based
- countdown_out  out  8  frames left in COUNTDOWN, else 0
- in_window_out  out  1  depth inside judging window
- game_state_out  out  3  0 LOSE, 1 IDLE, 2 WIN, 3 COUNTDOWN, 4 ADVANCE

## Operation
- The FSM has five states: IDLE → COUNTDOWN → ADVANCE → (COUNTDOWN | WIN | LOSE). WIN and LOSE hold until start_game_in.
- Start (start_game_in in IDLE/WIN/LOSE):
  - round=0, wall_idx=0, depth=0, strikes=0, frames_per_tick=MAX.
  - countdown=COUNTDOWN_FRAMES; enter COUNTDOWN.
- COUNTDOWN:
  - Each frame_done decrements countdown.
  - On frame_done with countdown==1: countdown→0, depth→0, frame counter→0, enter ADVANCE.
- ADVANCE:
  - Frame counter increments per frame_done.
  - When the counter equals frames_per_tick-1 at frame_done: counter→0, depth+1, wall_tick_out pulses.
- Judging, on every frame_done in ADVANCE using the pre-update depth:
  - In window and frame_collisions_in ≥ THRESHOLD: strikes+1.
  - In window and below THRESHOLD: strikes→0.
  - Outside the window: strikes→0.
  - strikes reaching STRIKE_FRAMES: enter LOSE.
- Round end: a tick taken at depth MAX_WALL_DEPTH-1 ends the round, with depth→0.
  - If round+1==MAX_ROUNDS: enter WIN.
  - Otherwise: round+1; wall_idx+1, wrapping NUM_WALLS-1→0; frames_per_tick=max(MAX−(round+1)·STEP, MIN), saturating with no underflow; strikes→0; reload countdown; enter COUNTDOWN.
- Simultaneous LOSE and round end on the same frame_done: LOSE wins.
- frame_done_in outside COUNTDOWN/ADVANCE is ignored. start_game_in in COUNTDOWN/ADVANCE is ignored.
- In WIN/LOSE: depth, round and wall_idx freeze; wall_tick_out=0.

## Timing
- Reset values: game_state_out=1, wall_idx_out=0, wall_depth_out=0, wall_tick_out=0, frames_per_tick_out=MAX_FRAMES_PER_WALL_TICK, round_out=0, countdown_out=0, in_window_out=0. Internal counters and strikes are also 0.
- Reset asserted mid-game returns all of the above on the next edge.
- Latency:
  - start_game_in sampled at edge t → COUNTDOWN visible after t.
  - frame_done_in at edge t → every resulting output change is visible after edge t, in one cycle.
- wall_tick_out is high exactly one cycle, coincident with the depth update.
- in_window_out is combinational from registered depth and registered as an output. It tracks wall_depth_out with the same cycle alignment.

## Structure
- Shared package game_pkg holds:
  - game state enum with explicit 3-bit encodings;
  - the depth and width constants used by the bit-mask and renderer modules.
- Sub-module wall_tick_gen holds the frame counter and tick pulse.
  - Inputs: clk_in, rst_in, clear, enable, frame_done, frames_per_tick.
  - Output: tick.
- The FSM, strike counter and round bookkeeping live in round_sequencer.

## Test plan
- Reset, then start_game_in=1 for 1 cycle → state 3, countdown_out=180. After 180 frame_done pulses → state 4, depth 0.
- Overrides COUNTDOWN_FRAMES=2, MAX_WALL_DEPTH=8, MAX_FRAMES=4; collisions=0 throughout:
  - Tick every 4th frame_done.
  - After 8 ticks → round_out=1, wall_idx_out=1, frames_per_tick_out=2.
  - WIN after round 4.
- Speed floor: MAX=5, STEP=2, MIN=3 → frames_per_tick sequence per round is 5, 3, 3, 3, 3.
- Collisions at depth 55 (in window):
  - frame_collisions_in = 70000, 70000, 10, 70000, 70000, 70000 → LOSE on the 6th frame_done, not the 2nd.
  - The same values at depth 40 → no LOSE.
- Strike limit coinciding with the round-end tick at depth MAX-1, with window widened to include it → state 0, round_out unchanged.
- Reset mid-ADVANCE (depth 30, round 2) → all outputs at reset values next cycle. start_game_in ignored in state 4; honoured in states 0 and 2.
